// File: rtl/bcd_serial_adder.sv
// bcd_serial_adder: multi-digit packed-BCD adder/subtractor, one digit per clock, LSD first.
//
// Ports:
//   Clock    in   system clock, rising edge
//   Resetn   in   synchronous active-low reset
//   Start    in   start request, sampled only in IDLE
//   Mode     in   0 = add (X+Y+Cin), 1 = subtract (X-Y-Cin)
//   Cin      in   carry-in (add) / borrow-in (subtract)
//   X, Y     in   packed BCD operands, digit 0 in [3:0]
//   Accum    in   (BCD_ACCUM_EN only) take X from the current result S
//   S        out  packed BCD result, updated only when the operation completes
//   Cout     out  add: decimal carry-out; subtract: 1 = no borrow
//   Busy     out  operation in progress
//   Done     out  one-cycle result-valid pulse
//   Invalid  out  an operand digit of the last operation was > 9
//
// Optional feature macro: BCD_ACCUM_EN (adds the Accum input for running totals).
module bcd_serial_adder #(
    parameter int DIGITS = 4,
    parameter int IW     = 3
) (
    input  logic                Clock,
    input  logic                Resetn,
    input  logic                Start,
    input  logic                Mode,
    input  logic                Cin,
    input  logic [4*DIGITS-1:0] X,
    input  logic [4*DIGITS-1:0] Y,
`ifdef BCD_ACCUM_EN
    input  logic                Accum,
`endif
    output logic [4*DIGITS-1:0] S,
    output logic                Cout,
    output logic                Busy,
    output logic                Done,
    output logic                Invalid
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e              r_state;
    state_e              w_state_next;

    logic [4*DIGITS-1:0] r_x;
    logic [4*DIGITS-1:0] r_y;
    logic [4*DIGITS-1:0] r_res;
    logic                r_mode;
    logic                r_c;
    logic [IW-1:0]       r_idx;
    logic                r_inv_acc;
    logic [4*DIGITS-1:0] r_s;
    logic                r_cout;
    logic                r_invalid;

    logic [3:0]          w_xd;
    logic [3:0]          w_yd;
    logic [4:0]          w_t;
    logic [3:0]          w_digit;
    logic                w_carry;
    logic                w_bad;
    logic                w_last;
    logic [4*DIGITS+3:0] w_cat;
    logic [4*DIGITS-1:0] w_res_next;
    logic [4*DIGITS-1:0] w_x_src;

    // Operands are shifted right each RUN cycle, so the current digit is always at [3:0].
    always_comb begin
        w_xd    = r_x[3:0];
        w_yd    = r_mode ? (4'd9 - r_y[3:0]) : r_y[3:0];
        w_t     = {1'b0, w_xd} + {1'b0, w_yd} + {4'b0000, r_c};
        w_carry = (w_t > 5'd9);
        // (t + 6) mod 16 only depends on t[3:0]
        w_digit = w_carry ? (w_t[3:0] + 4'd6) : w_t[3:0];
        w_bad   = (r_x[3:0] > 4'd9) | (r_y[3:0] > 4'd9);
        w_last  = (r_idx == IW'(DIGITS - 1));
        // New digit enters at the top; after DIGITS shifts digit 0 sits in [3:0].
        w_cat      = {w_digit, r_res};
        w_res_next = w_cat[4*DIGITS+3:4];
    end

`ifdef BCD_ACCUM_EN
    assign w_x_src = Accum ? r_s : X;
`else
    assign w_x_src = X;
`endif

    // State register
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:  if (Start) w_state_next = StRun;
            StRun:   if (w_last) w_state_next = StDone;
            StDone:  w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        Busy = (r_state == StRun);
        Done = (r_state == StDone);
    end

    // Datapath
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            r_x       <= '0;
            r_y       <= '0;
            r_res     <= '0;
            r_mode    <= 1'b0;
            r_c       <= 1'b0;
            r_idx     <= '0;
            r_inv_acc <= 1'b0;
            r_s       <= '0;
            r_cout    <= 1'b0;
            r_invalid <= 1'b0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (Start) begin
                        r_x       <= w_x_src;
                        r_y       <= Y;
                        r_mode    <= Mode;
                        // Subtract is X + (9's complement of Y) + ~borrow
                        r_c       <= Mode ? ~Cin : Cin;
                        r_idx     <= '0;
                        r_inv_acc <= 1'b0;
                    end
                end
                StRun: begin
                    r_x       <= r_x >> 4;
                    r_y       <= r_y >> 4;
                    r_res     <= w_res_next;
                    r_c       <= w_carry;
                    r_idx     <= r_idx + IW'(1);
                    r_inv_acc <= r_inv_acc | w_bad;
                    if (w_last) begin
                        r_s       <= w_res_next;
                        r_cout    <= w_carry;
                        r_invalid <= r_inv_acc | w_bad;
                    end
                end
                default: ;
            endcase
        end
    end

    assign S       = r_s;
    assign Cout    = r_cout;
    assign Invalid = r_invalid;

endmodule

// File: tb/tb_bcd_serial_adder.sv
module tb_bcd_serial_adder;

    localparam int DIGITS = 4;

    logic        Clock = 1'b0;
    logic        Resetn = 1'b0;
    logic        Start = 1'b0;
    logic        Mode = 1'b0;
    logic        Cin = 1'b0;
    logic [15:0] X = '0;
    logic [15:0] Y = '0;
    logic        accum = 1'b0;
    logic [15:0] S;
    logic        Cout;
    logic        Busy;
    logic        Done;
    logic        Invalid;

    int n_checks = 0;
    int n_pass   = 0;

    logic [15:0] res_s;
    logic        res_cout;
    logic        res_inv;

    bcd_serial_adder #(.DIGITS(DIGITS), .IW(3)) dut (
        .Clock   (Clock),
        .Resetn  (Resetn),
        .Start   (Start),
        .Mode    (Mode),
        .Cin     (Cin),
        .X       (X),
        .Y       (Y),
`ifdef BCD_ACCUM_EN
        .Accum   (accum),
`endif
        .S       (S),
        .Cout    (Cout),
        .Busy    (Busy),
        .Done    (Done),
        .Invalid (Invalid)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        logic        mode;
        logic        cin;
        logic [15:0] x;
        logic [15:0] y;
        logic        chk_s;
        logic [15:0] s;
        logic        cout;
        logic        inv;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    function automatic int bcd2int(input logic [15:0] v);
        int r = 0;
        for (int i = 3; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
        return r;
    endfunction

    function automatic logic [15:0] int2bcd(input int v);
        logic [15:0] r = '0;
        int t = v;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    // Issue one operation from IDLE, check handshake timing, capture results.
    task automatic run_op(input logic m, input logic c, input logic [15:0] x,
                          input logic [15:0] y, input logic acc);
        int  cyc = 0;
        int  bsy = 0;
        int  seen = 0;
        Mode = m; Cin = c; X = x; Y = y; accum = acc; Start = 1'b1;
        step();
        Start = 1'b0; accum = 1'b0;
        // Operands are latched: scramble the ports during RUN
        X = ~x; Y = ~y; Mode = ~m; Cin = ~c;
        while (cyc < 20) begin
            if (Done) begin
                seen = 1;
                break;
            end
            if (Busy) bsy++;
            step();
            cyc++;
        end
        check("done_seen", seen, 1);
        check("latency", cyc, DIGITS);
        check("busy_cycles", bsy, DIGITS);
        res_s = S; res_cout = Cout; res_inv = Invalid;
        step();
        check("done_pulse_end", int'(Done), 0);
        check("s_hold", int'(S), int'(res_s));
    endtask

    vec_t vecs[8];

    initial begin
        vecs[0] = '{1'b0, 1'b0, 16'h0999, 16'h0001, 1'b1, 16'h1000, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 16'h9999, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{1'b0, 1'b0, 16'h4567, 16'h5432, 1'b1, 16'h9999, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 1'b0, 16'h0500, 16'h0123, 1'b1, 16'h0377, 1'b1, 1'b0};
        vecs[4] = '{1'b1, 1'b0, 16'h0123, 16'h0500, 1'b1, 16'h9623, 1'b0, 1'b0};
        vecs[5] = '{1'b1, 1'b1, 16'h0500, 16'h0499, 1'b1, 16'h0000, 1'b1, 1'b0};
        vecs[6] = '{1'b0, 1'b0, 16'h00A0, 16'h0001, 1'b0, 16'h0000, 1'b0, 1'b1};
        vecs[7] = '{1'b0, 1'b0, 16'h0001, 16'h0001, 1'b1, 16'h0002, 1'b0, 1'b0};

        // Reset state
        step(); step();
        check("rst_busy", int'(Busy), 0);
        check("rst_done", int'(Done), 0);
        check("rst_s", int'(S), 0);
        check("rst_cout", int'(Cout), 0);
        check("rst_invalid", int'(Invalid), 0);
        Resetn = 1'b1;
        step();

        // Directed table
        foreach (vecs[i]) begin
            run_op(vecs[i].mode, vecs[i].cin, vecs[i].x, vecs[i].y, 1'b0);
            if (vecs[i].chk_s) begin
                check("vec_s", int'(res_s), int'(vecs[i].s));
                check("vec_cout", int'(res_cout), int'(vecs[i].cout));
            end
            check("vec_invalid", int'(res_inv), int'(vecs[i].inv));
        end

        // Reset during the second RUN cycle aborts without Done
        begin
            int dones = 0;
            Mode = 1'b0; Cin = 1'b0; X = 16'h1234; Y = 16'h1111; Start = 1'b1;
            step();
            Start = 1'b0;
            step();
            check("abort_busy_before", int'(Busy), 1);
            Resetn = 1'b0;
            step();
            check("abort_busy", int'(Busy), 0);
            check("abort_done", int'(Done), 0);
            check("abort_s", int'(S), 0);
            Resetn = 1'b1;
            for (int k = 0; k < 10; k++) begin
                if (Done) dones++;
                step();
            end
            check("abort_no_done", dones, 0);
        end

        // Start during RUN is ignored, nothing queued
        begin
            int cyc = 0;
            int busy_after = 0;
            Mode = 1'b0; Cin = 1'b0; X = 16'h0100; Y = 16'h0200; Start = 1'b1;
            step();
            Start = 1'b0;
            step();
            X = 16'h9000; Y = 16'h0005; Start = 1'b1;
            step();
            Start = 1'b0;
            while (!Done && cyc < 20) begin
                step();
                cyc++;
            end
            check("ignore_done", int'(Done), 1);
            check("ignore_s", int'(S), 16'h0300);
            for (int k = 0; k < 10; k++) begin
                step();
                if (Busy) busy_after++;
            end
            check("ignore_no_queue", busy_after, 0);
        end

        // Start held high: back-to-back period DIGITS+2
        begin
            int cyc = 0;
            int gap = 0;
            Mode = 1'b0; Cin = 1'b0; X = 16'h0002; Y = 16'h0003; Start = 1'b1;
            while (!Done && cyc < 20) begin
                step();
                cyc++;
            end
            check("b2b_first", int'(Done), 1);
            step();
            gap = 1;
            while (!Done && gap < 20) begin
                step();
                gap++;
            end
            Start = 1'b0;
            check("b2b_period", gap, DIGITS + 2);
            check("b2b_s", int'(S), 16'h0005);
            step(); step();
        end

        // Randomized against arithmetic model
        for (int n = 0; n < 40; n++) begin
            logic [15:0] x, y, es;
            logic        m, c, bad, ec;
            int          xi, yi, r;
            bad = 1'b0;
            for (int d = 0; d < 4; d++) begin
                x[4*d +: 4] = 4'($urandom_range(0, 9));
                y[4*d +: 4] = 4'($urandom_range(0, 9));
            end
            if ($urandom_range(0, 9) == 0) begin
                bad = 1'b1;
                if ($urandom_range(0, 1) == 0) x[4*$urandom_range(0, 3) +: 4] = 4'($urandom_range(10, 15));
                else y[4*$urandom_range(0, 3) +: 4] = 4'($urandom_range(10, 15));
            end
            m = 1'($urandom_range(0, 1));
            c = 1'($urandom_range(0, 1));
            xi = bcd2int(x);
            yi = bcd2int(y);
            if (!m) begin
                r  = xi + yi + int'(c);
                ec = (r >= 10000);
                es = int2bcd(r % 10000);
            end else begin
                r  = xi - yi - int'(c);
                ec = (r >= 0);
                es = int2bcd(r < 0 ? r + 10000 : r);
            end
            run_op(m, c, x, y, 1'b0);
            check("rnd_invalid", int'(res_inv), int'(bad));
            if (!bad) begin
                check("rnd_s", int'(res_s), int'(es));
                check("rnd_cout", int'(res_cout), int'(ec));
            end
        end

`ifdef BCD_ACCUM_EN
        // Running total: X port carries invalid digits that must be ignored
        run_op(1'b0, 1'b0, 16'h0999, 16'h0001, 1'b0);
        check("acc_s0", int'(res_s), 16'h1000);
        run_op(1'b0, 1'b0, 16'hFFFF, 16'h0234, 1'b1);
        check("acc_s1", int'(res_s), 16'h1234);
        check("acc_inv1", int'(res_inv), 0);
        run_op(1'b0, 1'b0, 16'hFFFF, 16'h8766, 1'b1);
        check("acc_s2", int'(res_s), 16'h0000);
        check("acc_cout2", int'(res_cout), 1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
